// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the 16-bit ALU datapath.
package alu_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

endpackage

// File: rtl/alu_acc_sequencer.sv
// Command front-end and accumulator around an external combinational ALU.
// Latency: result valid 2 cycles after command accept; one command in flight.
// Backpressure: result held stable until res_ready; cmd_ready low until then.
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data,
    output logic             res_err,
    output logic [WIDTH:0]   acc,
    output logic             err_state,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0] state;

    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign err_state = (state == ST_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            alu_x    <= '0;
            alu_y    <= '0;
            alu_op   <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            acc      <= '0;
            op_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc_clr) begin
                        acc <= '0;
                    end
                    if (cmd_valid) begin
                        // A coincident clear wins, so an accumulator-sourced x sees zero.
                        if (cmd_use_acc) begin
                            alu_x <= acc_clr ? '0 : acc[WIDTH-1:0];
                        end else begin
                            alu_x <= cmd_x;
                        end
                        alu_y  <= cmd_y;
                        alu_op <= cmd_op;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data <= alu_out;
                    res_err  <= alu_err;
                    if (!alu_err) begin
                        acc <= alu_out;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + 1'b1;
                        end
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        state <= res_err ? ST_ERROR : ST_IDLE;
                    end
                end
                default: begin
                    if (err_clr) begin
                        acc   <= '0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer with a behavioural ALU model and result scoreboard.
module tb_alu_acc_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_x = '0;
    logic [15:0] cmd_y = '0;
    logic        cmd_use_acc = 1'b0;
    logic        acc_clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] alu_x, alu_y;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic        alu_err;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_data;
    logic        res_err;
    logic [16:0] acc;
    logic        err_state;
    logic [7:0]  op_count;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_acc = '0;
    int          exp_cnt = 0;

    typedef struct { logic [16:0] d; logic e; } res_t;
    res_t sb[$];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic        ua;
        logic [16:0] ed;
        logic        ee;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_acc_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr), .err_clr(err_clr),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .acc(acc), .err_state(err_state), .op_count(op_count)
    );

    // External ALU: add/sub flag carry/borrow and output zero when they do.
    always_comb begin
        logic [16:0] t;
        alu_out = '0;
        alu_err = 1'b0;
        t = '0;
        case (alu_op)
            OP_ADD: begin
                t = {1'b0, alu_x} + {1'b0, alu_y};
                alu_err = t[16];
                alu_out = t[16] ? 17'h0 : t;
            end
            OP_SUB: begin
                alu_err = alu_x < alu_y;
                alu_out = alu_err ? 17'h0 : {1'b0, alu_x - alu_y};
            end
            OP_SHL:  alu_out = {alu_x, 1'b0};
            OP_SHR:  alu_out = {2'b00, alu_x[15:1]};
            OP_AND:  alu_out = {1'b0, alu_x & alu_y};
            OP_OR:   alu_out = {1'b0, alu_x | alu_y};
            OP_XOR:  alu_out = {1'b0, alu_x ^ alu_y};
            default: alu_out = {1'b0, ~alu_x};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic ua, input logic clr, input int hold,
                          input logic [16:0] ed, input logic ee);
        int   cyc;
        res_t r;
        @(negedge clk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_use_acc = ua; acc_clr = clr;
        sb.push_back('{ed, ee});
        @(negedge clk);
        cmd_valid = 1'b0; acc_clr = 1'b0; cmd_use_acc = 1'b0;
        cyc = 1;
        chk("cmd_ready_exec", {31'b0, cmd_ready}, 0);
        if (clr && ua) chk("clr_race_alu_x", {16'b0, alu_x}, 0);
        while (!res_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 2);
        if (!res_valid) return;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        r = sb.pop_front();
        chk("res_data", {15'b0, res_data}, {15'b0, r.d});
        chk("res_err", {31'b0, res_err}, {31'b0, r.e});
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_x = 16'($urandom); cmd_use_acc = 1'b0;
            @(negedge clk);
            chk("hold_valid", {31'b0, res_valid}, 1);
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 0);
            chk("hold_data", {15'b0, res_data}, {15'b0, r.d});
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_drop", {31'b0, res_valid}, 0);
        if (!ee) begin
            exp_acc = ed;
            if (exp_cnt < 255) exp_cnt++;
        end
        chk("acc", {15'b0, acc}, {15'b0, exp_acc});
        chk("op_count", {24'b0, op_count}, exp_cnt);
        chk("err_state", {31'b0, err_state}, {31'b0, ee});
        chk("cmd_ready_after", {31'b0, cmd_ready}, {31'b0, !ee});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{OP_ADD, 16'h0001, 16'h00FF, 1'b0, 17'h00100, 1'b0};
        vecs[1] = '{OP_SHL, 16'h0000, 16'h0000, 1'b1, 17'h00200, 1'b0};
        vecs[2] = '{OP_SHR, 16'h0000, 16'h0000, 1'b1, 17'h00100, 1'b0};
        vecs[3] = '{OP_XOR, 16'h00FF, 16'h0F0F, 1'b0, 17'h00FF0, 1'b0};
        vecs[4] = '{OP_SUB, 16'h0010, 16'h0003, 1'b0, 17'h0000D, 1'b0};
        vecs[5] = '{OP_NOT, 16'h00FF, 16'h0000, 1'b0, 17'h0FF00, 1'b0};
        vecs[6] = '{OP_OR,  16'h1200, 16'h0034, 1'b0, 17'h01234, 1'b0};
        vecs[7] = '{OP_ADD, 16'h0000, 16'h0001, 1'b1, 17'h01235, 1'b0};
        vecs[8] = '{OP_SHL, 16'h8001, 16'h0000, 1'b0, 17'h10002, 1'b0};
        vecs[9] = '{OP_SHR, 16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0};

        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_res_valid", {31'b0, res_valid}, 0);
        chk("rst_acc", {15'b0, acc}, 0);
        chk("rst_op_count", {24'b0, op_count}, 0);
        chk("rst_err_state", {31'b0, err_state}, 0);
        chk("rst_alu_op", {29'b0, alu_op}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].ua, 1'b0, 0, vecs[i].ed, vecs[i].ee);

        // Overflow: error response, then ERROR state ignores commands and acc_clr.
        run_op(OP_ADD, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 0, 17'h00000, 1'b1);
        cmd_valid = 1'b1; acc_clr = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0; acc_clr = 1'b0;
        chk("err_no_accept", {31'b0, res_valid}, 0);
        chk("err_acc_clr_ignored", {15'b0, acc}, 17'h00001);
        chk("err_hold", {31'b0, err_state}, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_state", {31'b0, err_state}, 0);
        chk("err_clr_ready", {31'b0, cmd_ready}, 1);
        chk("err_clr_acc", {15'b0, acc}, 0);
        exp_acc = '0;

        // Backpressure with competing commands offered during the hold.
        run_op(OP_AND, 16'h00E1, 16'h0B01, 1'b0, 1'b0, 5, 17'h00001, 1'b0);
        @(negedge clk);
        chk("bp_no_extra", {31'b0, res_valid}, 0);
        chk("bp_idle", {31'b0, cmd_ready}, 1);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_idle_acc", {15'b0, acc}, 17'h00001);

        // Clear racing an accumulator-sourced accept.
        run_op(OP_ADD, 16'h0001, 16'h00FF, 1'b0, 1'b0, 0, 17'h00100, 1'b0);
        run_op(OP_OR, 16'hFFFF, 16'h0F00, 1'b1, 1'b1, 0, 17'h00F00, 1'b0);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("idle_acc_clr", {15'b0, acc}, 0);
        chk("idle_acc_clr_cnt", {24'b0, op_count}, exp_cnt);

        // Async reset while the command is in EXEC.
        cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_x = 16'h1234; cmd_y = 16'h4321;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_reset_exec", {31'b0, cmd_ready}, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_acc", {15'b0, acc}, 0);
        chk("ar_cnt", {24'b0, op_count}, 0);
        chk("ar_alu_x", {16'b0, alu_x}, 0);
        chk("ar_res_valid", {31'b0, res_valid}, 0);
        chk("ar_res_data", {15'b0, res_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar_no_resp", {31'b0, res_valid}, 0);
        end
        chk("ar_ready", {31'b0, cmd_ready}, 1);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
